// File: rtl/chan_pkg.sv
// Shared widths, buffer state encoding and helpers for the channel router.
package chan_pkg;

    localparam int unsigned CHAN_ADDR_W = 7;
    localparam int unsigned CHAN_DATA_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // A single slot still needs a 1-bit tag so the bus is never zero width.
    function automatic int unsigned tag_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/chan_skid2.sv
// Two-entry tagged write buffer with a per-head stall watchdog.
module chan_skid2
    import chan_pkg::*;
#(
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    input  logic [CHAN_DATA_W-1:0] wr_data_i,
    input  logic [TAG_W-1:0]       wr_tag_i,
    input  logic                   wr_discard_i,
    input  logic                   head_ready_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   head_valid_o,
    output logic [CHAN_DATA_W-1:0] head_data_o,
    output logic [TAG_W-1:0]       head_tag_o,
    output logic                   drop_o
);

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    buf_state_e             state_q;
    logic [CHAN_DATA_W-1:0] hd_data_q, tl_data_q;
    logic [TAG_W-1:0]       hd_tag_q, tl_tag_q;
    logic                   hd_disc_q, tl_disc_q;
    logic [15:0]            wd_q;

    logic push, pop, accept, timeout;

    assign ready_o      = (state_q != TWO);
    assign busy_o       = (state_q != EMPTY);
    assign head_valid_o = busy_o & ~hd_disc_q;
    assign head_data_o  = hd_data_q;
    assign head_tag_o   = hd_tag_q;

    assign push    = wr_valid_i & ready_o;
    assign accept  = head_valid_o & head_ready_i;
    assign timeout = head_valid_o & ~head_ready_i & (wd_q == WD_LIMIT);
    // Discarded entries leave as soon as they reach the head.
    assign pop     = busy_o & (hd_disc_q | accept | timeout);
    assign drop_o  = timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            hd_data_q <= '0;
            hd_tag_q  <= '0;
            hd_disc_q <= 1'b0;
            tl_data_q <= '0;
            tl_tag_q  <= '0;
            tl_disc_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        hd_data_q <= wr_data_i;
                        hd_tag_q  <= wr_tag_i;
                        hd_disc_q <= wr_discard_i;
                        state_q   <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        hd_data_q <= wr_data_i;
                        hd_tag_q  <= wr_tag_i;
                        hd_disc_q <= wr_discard_i;
                    end else if (push) begin
                        tl_data_q <= wr_data_i;
                        tl_tag_q  <= wr_tag_i;
                        tl_disc_q <= wr_discard_i;
                        state_q   <= TWO;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        hd_data_q <= tl_data_q;
                        hd_tag_q  <= tl_tag_q;
                        hd_disc_q <= tl_disc_q;
                        state_q   <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase

            if (pop || (state_q == EMPTY)) begin
                wd_q <= '0;
            end else if (head_valid_o) begin
                wd_q <= wd_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/chan_router.sv
// Routes comm_fpga channel traffic to NUM_SLOTS endpoints: buffered writes, combinational reads.
module chan_router
    import chan_pkg::*;
#(
    parameter int unsigned            NUM_SLOTS = 4,
    parameter logic [CHAN_ADDR_W-1:0] BASE_ADDR = 7'h00,
    parameter int unsigned            TIMEOUT   = 255
) (
    input  logic                             clk_in,
    input  logic                             reset_n_in,
    input  logic [CHAN_ADDR_W-1:0]           chanAddr_in,
    input  logic [CHAN_DATA_W-1:0]           h2fData_in,
    input  logic                             h2fValid_in,
    output logic                             h2fReady_out,
    output logic [CHAN_DATA_W-1:0]           f2hData_out,
    output logic                             f2hValid_out,
    input  logic                             f2hReady_in,
    output logic [CHAN_DATA_W-1:0]           slotH2fData_out,
    output logic [NUM_SLOTS-1:0]             slotH2fValid_out,
    input  logic [NUM_SLOTS-1:0]             slotH2fReady_in,
    input  logic [CHAN_DATA_W*NUM_SLOTS-1:0] slotF2hData_in,
    input  logic [NUM_SLOTS-1:0]             slotF2hValid_in,
    output logic [NUM_SLOTS-1:0]             slotF2hReady_out,
    output logic [7:0]                       dropCount_out,
    output logic                             busy_out
);

    localparam int unsigned TAG_W = tag_width(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] hit_vec;
    logic                 hit;
    logic [TAG_W-1:0]     slot;
    logic                 head_valid, head_ready, drop;
    logic [TAG_W-1:0]     head_tag;
    logic [7:0]           drop_q;

    // Compare in 32 bits so BASE_ADDR+k never wraps into a false hit.
    always_comb begin
        hit_vec = '0;
        slot    = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if ({25'd0, chanAddr_in} == ({25'd0, BASE_ADDR} + k)) begin
                hit_vec[k] = 1'b1;
                slot       = TAG_W'(k);
            end
        end
    end

    assign hit = |hit_vec;

    chan_skid2 #(
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) u_skid (
        .clk_i        (clk_in),
        .rst_ni       (reset_n_in),
        .wr_valid_i   (h2fValid_in),
        .wr_data_i    (h2fData_in),
        .wr_tag_i     (slot),
        .wr_discard_i (~hit),
        .head_ready_i (head_ready),
        .ready_o      (h2fReady_out),
        .busy_o       (busy_out),
        .head_valid_o (head_valid),
        .head_data_o  (slotH2fData_out),
        .head_tag_o   (head_tag),
        .drop_o       (drop)
    );

    always_comb begin
        slotH2fValid_out = '0;
        head_ready       = 1'b0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (head_tag == TAG_W'(k)) begin
                slotH2fValid_out[k] = head_valid;
                head_ready          = slotH2fReady_in[k];
            end
        end
    end

    // Reads wait for the write buffer to drain so read-after-write is coherent.
    always_comb begin
        f2hData_out      = '0;
        f2hValid_out     = ~hit & ~busy_out;
        slotF2hReady_out = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (hit_vec[k]) begin
                f2hData_out         = slotF2hData_in[CHAN_DATA_W*k +: CHAN_DATA_W];
                f2hValid_out        = slotF2hValid_in[k] & ~busy_out;
                slotF2hReady_out[k] = f2hReady_in & ~busy_out;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign dropCount_out = drop_q;

endmodule

// File: tb/tb_chan_router.sv
// Self-checking bench for chan_router: queue-based reference model plus directed scenarios.
module tb_chan_router;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  chan_addr;
    logic [7:0]  h2f_data;
    logic        h2f_valid;
    logic        h2f_ready;
    logic [7:0]  f2h_data;
    logic        f2h_valid;
    logic        f2h_ready;
    logic [7:0]  slot_h2f_data;
    logic [3:0]  slot_h2f_valid;
    logic [3:0]  slot_h2f_ready;
    logic [31:0] slot_f2h_data;
    logic [3:0]  slot_f2h_valid;
    logic [3:0]  slot_f2h_ready;
    logic [7:0]  drop_count;
    logic        busy;

    always #5 clk = ~clk;

    chan_router #(
        .NUM_SLOTS (4),
        .BASE_ADDR (7'h00),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk_in           (clk),
        .reset_n_in       (rst_n),
        .chanAddr_in      (chan_addr),
        .h2fData_in       (h2f_data),
        .h2fValid_in      (h2f_valid),
        .h2fReady_out     (h2f_ready),
        .f2hData_out      (f2h_data),
        .f2hValid_out     (f2h_valid),
        .f2hReady_in      (f2h_ready),
        .slotH2fData_out  (slot_h2f_data),
        .slotH2fValid_out (slot_h2f_valid),
        .slotH2fReady_in  (slot_h2f_ready),
        .slotF2hData_in   (slot_f2h_data),
        .slotF2hValid_in  (slot_f2h_valid),
        .slotF2hReady_out (slot_f2h_ready),
        .dropCount_out    (drop_count),
        .busy_out         (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         tag;
        bit         discard;
    } ent_t;

    ent_t q[$];
    int   m_wd;
    int   m_drops;
    bit   m_push, m_pop, m_drop;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int         sz;
        int         a;
        logic [3:0] exp_sv;
        logic [3:0] exp_fr;
        logic [7:0] exp_fd;
        logic       exp_fv;
        sz     = q.size();
        a      = int'(chan_addr);
        exp_sv = '0;
        exp_fr = '0;
        chk("h2fReady", 32'(h2f_ready), 32'(sz < 2));
        chk("busy", 32'(busy), 32'(sz != 0));
        if (sz > 0 && !q[0].discard) exp_sv[q[0].tag] = 1'b1;
        chk("slotH2fValid", 32'(slot_h2f_valid), 32'(exp_sv));
        if (sz > 0) chk("slotH2fData", 32'(slot_h2f_data), 32'(q[0].data));
        chk("dropCount", 32'(drop_count), 32'(m_drops));
        if (a < 4) begin
            exp_fd = slot_f2h_data[a*8 +: 8];
            exp_fv = slot_f2h_valid[a] && (sz == 0);
            if (f2h_ready && sz == 0) exp_fr[a] = 1'b1;
        end else begin
            exp_fd = 8'h00;
            exp_fv = (sz == 0);
        end
        chk("f2hData", 32'(f2h_data), 32'(exp_fd));
        chk("f2hValid", 32'(f2h_valid), 32'(exp_fv));
        chk("slotF2hReady", 32'(slot_f2h_ready), 32'(exp_fr));
    endtask

    task automatic model_eval();
        m_push = h2f_valid && (q.size() < 2);
        m_pop  = 1'b0;
        m_drop = 1'b0;
        if (q.size() > 0) begin
            if (q[0].discard || slot_h2f_ready[q[0].tag]) begin
                m_pop = 1'b1;
            end else if (m_wd == TB_TIMEOUT - 1) begin
                m_pop  = 1'b1;
                m_drop = 1'b1;
            end
        end
    endtask

    task automatic model_apply();
        ent_t e;
        if (q.size() == 0 || m_pop) m_wd = 0;
        else m_wd++;
        if (m_pop) void'(q.pop_front());
        if (m_drop && m_drops < 255) m_drops++;
        if (m_push) begin
            e.data    = h2f_data;
            e.discard = (int'(chan_addr) >= 4);
            e.tag     = e.discard ? 0 : int'(chan_addr);
            q.push_back(e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wd    = 0;
        m_drops = 0;
    endtask

    // Entered just after a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1;
        compare_all();
        model_eval();
        @(posedge clk);
        if (rst_n) model_apply();
        @(negedge clk);
    endtask

    task automatic set_idle();
        chan_addr      = 7'h00;
        h2f_data       = 8'h00;
        h2f_valid      = 1'b0;
        f2h_ready      = 1'b0;
        slot_h2f_ready = 4'hF;
        slot_f2h_data  = 32'h0;
        slot_f2h_valid = 4'h0;
    endtask

    task automatic write(input logic [6:0] addr, input logic [7:0] data);
        chan_addr = addr;
        h2f_data  = data;
        h2f_valid = 1'b1;
    endtask

    initial begin
        int rdy_pct;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_h2fReady", 32'(h2f_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_slotValid", 32'(slot_h2f_valid), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write delivered one cycle after the push edge.
        write(7'h02, 8'h5A);
        cycle();
        h2f_valid = 1'b0;
        #1;
        chk("t1_valid", 32'(slot_h2f_valid), 32'h4);
        chk("t1_data", 32'(slot_h2f_data), 32'h5A);
        cycle();
        #1;
        chk("t1_busy_clear", 32'(busy), 32'd0);
        cycle();

        // Slot 1 stalled: buffer fills, then drains in order.
        slot_h2f_ready = 4'b1101;
        write(7'h01, 8'h11);
        cycle();
        write(7'h01, 8'h22);
        cycle();
        write(7'h01, 8'h33);
        #1;
        chk("t2_full", 32'(h2f_ready), 32'd0);
        slot_h2f_ready = 4'hF;
        #1;
        chk("t2_first", 32'(slot_h2f_data), 32'h11);
        cycle();
        #1;
        chk("t2_second", 32'(slot_h2f_data), 32'h22);
        chk("t2_second_v", 32'(slot_h2f_valid), 32'h2);
        cycle();
        h2f_valid = 1'b0;
        #1;
        chk("t2_third", 32'(slot_h2f_data), 32'h33);
        cycle();
        cycle();

        // Tags stick to entries across chanAddr changes.
        slot_h2f_ready = 4'b0111;
        write(7'h03, 8'hAA);
        cycle();
        write(7'h00, 8'hBB);
        #1;
        chk("t3_aa_v", 32'(slot_h2f_valid), 32'h8);
        cycle();
        h2f_valid      = 1'b0;
        slot_h2f_ready = 4'hF;
        #1;
        chk("t3_aa_d", 32'(slot_h2f_data), 32'hAA);
        chk("t3_aa_v2", 32'(slot_h2f_valid), 32'h8);
        cycle();
        #1;
        chk("t3_bb_v", 32'(slot_h2f_valid), 32'h1);
        chk("t3_bb_d", 32'(slot_h2f_data), 32'hBB);
        cycle();
        cycle();

        // Watchdog drop after TB_TIMEOUT stalled cycles.
        slot_h2f_ready = 4'b1011;
        write(7'h02, 8'h77);
        cycle();
        h2f_valid = 1'b0;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            #1;
            chk("t4_stalled", 32'(slot_h2f_valid), 32'h4);
            cycle();
        end
        #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_drop", 32'(drop_count), 32'd1);
        chk("t4_novalid", 32'(slot_h2f_valid), 32'd0);
        slot_h2f_ready = 4'hF;
        cycle();

        // Combinational reads.
        chan_addr = 7'h7F;
        #1;
        chk("t5_unmapped_d", 32'(f2h_data), 32'h00);
        chk("t5_unmapped_v", 32'(f2h_valid), 32'd1);
        cycle();
        chan_addr      = 7'h01;
        slot_f2h_valid = 4'b0010;
        slot_f2h_data  = 32'h00_00_C3_00;
        f2h_ready      = 1'b1;
        #1;
        chk("t5_rd_d", 32'(f2h_data), 32'hC3);
        chk("t5_rd_ack", 32'(slot_f2h_ready), 32'h2);
        cycle();
        f2h_ready = 1'b0;
        #1;
        chk("t5_rd_noack", 32'(slot_f2h_ready), 32'h0);
        cycle();
        set_idle();

        // Asynchronous reset with the buffer full.
        slot_h2f_ready = 4'h0;
        write(7'h00, 8'h01);
        cycle();
        write(7'h00, 8'h02);
        cycle();
        h2f_valid = 1'b0;
        #1;
        chk("t6_full", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(h2f_ready), 32'd1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(slot_h2f_valid), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        model_reset();
        cycle();
        rst_n          = 1'b1;
        slot_h2f_ready = 4'hF;
        write(7'h02, 8'h3C);
        cycle();
        h2f_valid = 1'b0;
        #1;
        chk("t6_fresh_v", 32'(slot_h2f_valid), 32'h4);
        chk("t6_fresh_d", 32'(slot_h2f_data), 32'h3C);
        cycle();

        // Randomized traffic against the model.
        rdy_pct = 90;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rdy_pct = (n % 600 == 0) ? 90 : ((n % 600 == 200) ? 50 : 15);
            chan_addr = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 3))
                                                   : 7'($urandom_range(0, 127));
            h2f_data       = 8'($urandom);
            h2f_valid      = ($urandom_range(0, 2) != 0);
            f2h_ready      = 1'($urandom);
            slot_f2h_data  = $urandom;
            slot_f2h_valid = 4'($urandom);
            for (int b = 0; b < 4; b++) slot_h2f_ready[b] = ($urandom_range(0, 99) < rdy_pct);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
